muldiv_unit: RTL and testbench

Multi-cycle multiply/divide unit with HI/LO registers for the MIPS datapath. Sits directly downstream of the register file. Takes the two register-file read operands as inputs, runs MULT/MULTU/DIV/DIVU over a fixed number of cycles, and holds the 64-bit result in HI/LO for MFHI/MFLO. Asserts `Busy` so the pipeline control can stall dependent HI/LO instructions.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_calc.sv | 68 ++++++
 rtl/muldiv_unit.sv | 127 ++++++++++++
 tb/tb_muldiv_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared definitions for the multiply/divide unit and the control decoder
//   that drives it: operation encodings on the 3-bit Op bus, the FSM state
//   encoding, and the default busy-period lengths.
package muldiv_pkg;

   // Operation encodings carried on Op; 3'b110 and 3'b111 are reserved no-ops.
   typedef enum logic [2:0] {
      MD_MULT  = 3'b000,
      MD_MULTU = 3'b001,
      MD_DIV   = 3'b010,
      MD_DIVU  = 3'b011,
      MD_MTHI  = 3'b100,
      MD_MTLO  = 3'b101
   } md_op_e;

   // Controller states: waiting for a request, or counting down an operation.
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   // Default busy-period lengths in clock cycles.
   localparam int DEFAULT_MULT_CYCLES = 5;
   localparam int DEFAULT_DIV_CYCLES  = 10;

endpackage

// File: rtl/muldiv_calc.sv
// muldiv_calc
//   Purely combinational 64-bit result generator for MULT/MULTU/DIV/DIVU.
//   Ports:
//     op          in  md_op_e  operation select (non-arithmetic ops give 0)
//     a, b        in  32       rs / rt operands
//     result      out 64       {hi, lo}: product, or {remainder, quotient}
//     div_by_zero out 1        divide op with b == 0; result is meaningless
module muldiv_calc
   import muldiv_pkg::*;
(
   input  md_op_e      op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] result,
   output logic        div_by_zero
);

   logic signed [63:0] a_sext;
   logic signed [63:0] b_sext;
   logic        [63:0] prod_signed;
   logic        [63:0] prod_unsigned;
   logic               div_signed;
   logic        [31:0] mag_a;
   logic        [31:0] mag_b;
   logic        [31:0] divisor;
   logic        [31:0] quot_mag;
   logic        [31:0] rem_mag;
   logic        [31:0] quot;
   logic        [31:0] rem;

   // Both products come from 64-bit operands so the low 64 bits of the
   // multiply are the exact 32x32 result in each signedness.
   // Signed divide runs on magnitudes, then the quotient takes the XOR of the
   // operand signs and the remainder takes the sign of the dividend, which
   // gives truncation toward zero. The INT_MIN / -1 case falls out of this
   // naturally: |INT_MIN| is 0x80000000 unsigned, the quotient magnitude is
   // 0x80000000 and both signs cancel, so LO=0x80000000 and HI=0 with no trap.
   // A zero divisor is replaced by 1 purely to keep the divider well defined;
   // the flag tells the unit to discard the result.
   always_comb begin
      a_sext        = {{32{a[31]}}, a};
      b_sext        = {{32{b[31]}}, b};
      prod_signed   = a_sext * b_sext;
      prod_unsigned = {32'd0, a} * {32'd0, b};

      div_signed = (op == MD_DIV);
      mag_a      = (div_signed && a[31]) ? (~a + 32'd1) : a;
      mag_b      = (div_signed && b[31]) ? (~b + 32'd1) : b;
      divisor    = (b == 32'd0) ? 32'd1 : mag_b;
      quot_mag   = mag_a / divisor;
      rem_mag    = mag_a % divisor;
      quot       = (div_signed && (a[31] ^ b[31])) ? (~quot_mag + 32'd1) : quot_mag;
      rem        = (div_signed && a[31]) ? (~rem_mag + 32'd1) : rem_mag;

      result      = 64'd0;
      div_by_zero = 1'b0;
      case (op)
         MD_MULT:  result = prod_signed;
         MD_MULTU: result = prod_unsigned;
         MD_DIV, MD_DIVU: begin
            result      = {rem, quot};
            div_by_zero = (b == 32'd0);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Multi-cycle multiply/divide unit with HI/LO registers. The result of an
//   arithmetic op is computed at the accepting edge and held pending; HI/LO
//   are written only when the busy period expires.
//   Parameters: MULT_CYCLES / DIV_CYCLES busy-period lengths (>= 1).
//   Ports:
//     Clk   in  1   clock, rising edge
//     Reset in  1   synchronous active-high reset
//     Start in  1   one-cycle request, sampled with Op/A/B
//     Op    in  3   operation (see muldiv_pkg)
//     A, B  in  32  rs / rt operands
//     Busy  out 1   operation in flight (registered)
//     HI,LO out 32  HI/LO registers
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [2:0]  Op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   md_op_e           op_e;
   logic [63:0]      calc_result;
   logic             calc_dz;

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [63:0]      pend_q, pend_d;
   logic             pend_dz_q, pend_dz_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;

   assign op_e = md_op_e'(Op);

   muldiv_calc u_calc (
      .op          (op_e),
      .a           (A),
      .b           (B),
      .result      (calc_result),
      .div_by_zero (calc_dz)
   );

   // Requests are only looked at in IDLE, so anything arriving while RUN
   // (including MTHI/MTLO) is dropped rather than queued. The counter is
   // loaded with N and the write-back happens on the edge that takes it from
   // 1 to 0, which keeps Busy high for exactly N cycles.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      pend_dz_d = pend_dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               case (op_e)
                  MD_MULT, MD_MULTU: begin
                     pend_d    = calc_result;
                     pend_dz_d = 1'b0;
                     cnt_d     = CNT_W'(MULT_CYCLES);
                     state_d   = ST_RUN;
                  end
                  MD_DIV, MD_DIVU: begin
                     pend_d    = calc_result;
                     pend_dz_d = calc_dz;
                     cnt_d     = CNT_W'(DIV_CYCLES);
                     state_d   = ST_RUN;
                  end
                  MD_MTHI: hi_d = A;
                  MD_MTLO: lo_d = A;
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               if (!pend_dz_q) begin
                  hi_d = pend_q[63:32];
                  lo_d = pend_q[31:0];
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Reset clears everything, including any pending result, so an aborted
   // operation can never write back late.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pend_q    <= '0;
         pend_dz_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         pend_dz_q <= pend_dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign Busy = (state_q == ST_RUN);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit: a directed sequence with literal
//   expectations followed by a randomized phase, all compared every cycle
//   against a timestamp-based behavioural model.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        Clk;
   logic        Reset;
   logic        Start;
   logic [2:0]  Op;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int vectors    = 0;
   int miscompares = 0;

   // Behavioural model state: completion is tracked as an absolute cycle
   // number rather than a countdown.
   int          cycleNum  = 0;
   bit          mValid    = 0;
   bit          mRun      = 0;
   int          mDoneCyc  = 0;
   logic [64:0] mPend     = '0;
   logic [31:0] mHi       = '0;
   logic [31:0] mLo       = '0;

   muldiv_unit #(
      .MULT_CYCLES (MULT_N),
      .DIV_CYCLES  (DIV_N)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .Start (Start),
      .Op    (Op),
      .A     (A),
      .B     (B),
      .Busy  (Busy),
      .HI    (HI),
      .LO    (LO)
   );

   // Free-running clock, period 10.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Reference arithmetic: returns {div_by_zero, hi, lo} using plain
   // SystemVerilog integer arithmetic.
   function automatic logic [64:0] modelCalc(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      longint          sp;
      longint unsigned up;
      int              sa;
      int              sb;
      int              q;
      int              r;
      logic [64:0]     res;
      res = '0;
      sa  = a;
      sb  = b;
      case (op)
         3'b000: begin
            sp  = longint'(sa) * longint'(sb);
            res = {1'b0, sp[63:0]};
         end
         3'b001: begin
            up  = longint'({32'd0, a}) * longint'({32'd0, b});
            res = {1'b0, up[63:0]};
         end
         3'b010: begin
            if (b == 32'd0) res = {1'b1, 64'd0};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {1'b0, 32'd0, 32'h8000_0000};
            else begin
               q   = sa / sb;
               r   = sa % sb;
               res = {1'b0, r, q};
            end
         end
         3'b011: begin
            if (b == 32'd0) res = {1'b1, 64'd0};
            else res = {1'b0, a % b, a / b};
         end
         default: res = '0;
      endcase
      return res;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d",
                  name, actual, expected, cycleNum);
      end
   endtask

   // Drives one request for a single cycle; caller is at a negedge and the
   // task returns at the negedge following the sampling edge.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b);
      Start = 1'b1;
      Op    = op;
      A     = a;
      B     = b;
      @(negedge Clk);
      Start = 1'b0;
   endtask

   // Counts remaining Busy cycles, bounded so a stuck unit cannot hang us.
   task automatic waitIdle(output int n);
      n = 0;
      while (Busy === 1'b1 && n < 200) begin
         n++;
         @(negedge Clk);
      end
      if (n >= 200) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL busy_timeout: Busy still high after %0d cycles, expected low", n);
      end
   endtask

   // Model update on each rising edge, then compare all outputs just after.
   always @(posedge Clk) begin
      logic [64:0] r;
      cycleNum++;
      if (Reset) begin
         mValid = 1;
         mRun   = 0;
         mHi    = '0;
         mLo    = '0;
      end else if (mValid) begin
         if (mRun) begin
            if (cycleNum == mDoneCyc) begin
               mRun = 0;
               if (!mPend[64]) begin
                  mHi = mPend[63:32];
                  mLo = mPend[31:0];
               end
            end
         end else if (Start) begin
            case (Op)
               MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                  r        = modelCalc(Op, A, B);
                  mPend    = r;
                  mRun     = 1;
                  mDoneCyc = cycleNum + ((Op == MD_MULT || Op == MD_MULTU) ? MULT_N : DIV_N);
               end
               MD_MTHI: mHi = A;
               MD_MTLO: mLo = A;
               default: ;
            endcase
         end
      end
      #1;
      if (mValid) begin
         checkOutput("busy", {31'd0, Busy}, {31'd0, mRun});
         checkOutput("hi", HI, mHi);
         checkOutput("lo", LO, mLo);
      end
   end

   initial begin
      int          n;
      logic [64:0] pin;
      Reset = 1'b1;
      Start = 1'b0;
      Op    = 3'b000;
      A     = '0;
      B     = '0;

      // Pin the model to hand-computed values.
      pin = modelCalc(MD_MULT, 32'hFFFF_FFFE, 32'd3);
      checkOutput("model_mult_hi", pin[63:32], 32'hFFFF_FFFF);
      checkOutput("model_mult_lo", pin[31:0], 32'hFFFF_FFFA);
      pin = modelCalc(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      checkOutput("model_div_lo", pin[31:0], 32'hFFFF_FFFD);
      checkOutput("model_div_hi", pin[63:32], 32'hFFFF_FFFF);
      pin = modelCalc(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      checkOutput("model_intmin_lo", pin[31:0], 32'h8000_0000);

      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      checkOutput("reset_hi", HI, 32'd0);
      checkOutput("reset_lo", LO, 32'd0);
      checkOutput("reset_busy", {31'd0, Busy}, 32'd0);

      applyStimulus(MD_MTHI, 32'h1234_5678, 32'd0);
      checkOutput("mthi_hi", HI, 32'h1234_5678);
      checkOutput("mthi_busy", {31'd0, Busy}, 32'd0);

      applyStimulus(MD_MULT, 32'hFFFF_FFFE, 32'd3);
      waitIdle(n);
      checkOutput("mult_busy_len", n, MULT_N);
      checkOutput("mult_hi", HI, 32'hFFFF_FFFF);
      checkOutput("mult_lo", LO, 32'hFFFF_FFFA);

      applyStimulus(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
      waitIdle(n);
      checkOutput("multu_hi", HI, 32'h0000_0002);
      checkOutput("multu_lo", LO, 32'hFFFF_FFFA);

      applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      waitIdle(n);
      checkOutput("div_busy_len", n, DIV_N);
      checkOutput("div_lo", LO, 32'hFFFF_FFFD);
      checkOutput("div_hi", HI, 32'hFFFF_FFFF);

      applyStimulus(MD_DIVU, 32'd7, 32'd2);
      waitIdle(n);
      checkOutput("divu_lo", LO, 32'd3);
      checkOutput("divu_hi", HI, 32'd1);

      applyStimulus(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      waitIdle(n);
      checkOutput("intmin_lo", LO, 32'h8000_0000);
      checkOutput("intmin_hi", HI, 32'd0);

      applyStimulus(MD_MTHI, 32'hAAAA_0000, 32'd0);
      applyStimulus(MD_MTLO, 32'h0000_5555, 32'd0);
      applyStimulus(MD_DIVU, 32'd1234, 32'd0);
      waitIdle(n);
      checkOutput("divzero_busy_len", n, DIV_N);
      checkOutput("divzero_hi", HI, 32'hAAAA_0000);
      checkOutput("divzero_lo", LO, 32'h0000_5555);

      // Requests while busy must be dropped without stretching Busy.
      applyStimulus(MD_MULT, 32'h10, 32'h20);
      applyStimulus(MD_MTLO, 32'hDEAD_BEEF, 32'd0);
      applyStimulus(MD_DIV, 32'd100, 32'd7);
      waitIdle(n);
      checkOutput("ignored_busy_len", n + 2, MULT_N);
      checkOutput("ignored_hi", HI, 32'd0);
      checkOutput("ignored_lo", LO, 32'h200);

      // Reset sampled at the third busy edge aborts the operation.
      applyStimulus(MD_MULT, 32'd5, 32'd7);
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      checkOutput("abort_busy", {31'd0, Busy}, 32'd0);
      checkOutput("abort_hi", HI, 32'd0);
      checkOutput("abort_lo", LO, 32'd0);
      repeat (5) @(negedge Clk);
      checkOutput("abort_late_lo", LO, 32'd0);

      // Randomized phase; the per-cycle compare process does the checking.
      for (int i = 0; i < 1500; i++) begin
         int sel;
         Reset = ($urandom_range(0, 79) == 0);
         Start = 1'($urandom_range(0, 1));
         Op    = 3'($urandom_range(0, 7));
         A     = $urandom;
         sel   = $urandom_range(0, 9);
         case (sel)
            0: B = 32'd0;
            1: begin A = 32'h8000_0000; B = 32'hFFFF_FFFF; end
            2: B = 32'($urandom_range(1, 16));
            3: B = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            default: B = $urandom;
         endcase
         @(negedge Clk);
      end
      Reset = 1'b0;
      Start = 1'b0;
      repeat (DIV_N + 2) @(negedge Clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
